// File: rtl/vga_pkg.sv
// Shared VGA pipeline constants and types: card bitmap geometry, transparent key colour
// and the packed timing bundle carried alongside each pixel.
package vga_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 11;
    localparam int RGB_W    = 12;

    localparam int CARD_WIDTH  = 48;
    localparam int CARD_HEIGHT = 64;
    localparam int CARD_COL_W  = 6;
    localparam int CARD_ROW_W  = 6;

    localparam logic [RGB_W-1:0] TRANSPARENT_RGB = 12'hF0F;

    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        logic [VCOUNT_W-1:0] vcount;
        logic                hsync;
        logic                vsync;
        logic                hblnk;
        logic                vblnk;
    } vga_timing_t;

    localparam int TIMING_W = $bits(vga_timing_t);

    // The card ROM is laid out row-major with a 64-entry row pitch.
    function automatic logic [CARD_ROW_W+CARD_COL_W-1:0] card_rom_addr(
        input logic [CARD_ROW_W-1:0] row,
        input logic [CARD_COL_W-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/delay.sv
// Fixed-length shift register with synchronous reset, used to keep the VGA timing
// bundle aligned with pixel data through a pipeline of CLK_DEL stages.
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [CLK_DEL];

    // NOTE: every stage is reset, not just the last one: each is live pipeline state
    // whose stale contents would otherwise surface on q during the refill after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < CLK_DEL; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[CLK_DEL-1];

endmodule

// File: rtl/draw_card.sv
// Overlays a 48x64 card bitmap from a synchronous ROM onto the VGA stream at a position
// latched once per frame. Optional macro DRAW_CARD_TRANSPARENT_EN keys out 12'hF0F pixels.
module draw_card
    import vga_pkg::*;
#(
    parameter int XPOS_W = 12,
    parameter int DLY    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                hblnk_in,
    input  logic                vblnk_in,
    input  logic [RGB_W-1:0]    rgb_in,
    input  logic [XPOS_W-1:0]   xpos,
    input  logic [XPOS_W-1:0]   ypos,
    input  logic                card_en,
    output logic [11:0]         rom_addr,
    input  logic [RGB_W-1:0]    rom_rgb,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                hblnk_out,
    output logic                vblnk_out,
    output logic [RGB_W-1:0]    rgb_out
);

    // One extra bit so a card hanging past the right/bottom edge compares without wrapping.
    localparam int EXT_W = XPOS_W + 1;

    logic [XPOS_W-1:0] xpos_l;
    logic [XPOS_W-1:0] ypos_l;
    logic              card_en_l;
    logic              vblnk_prev;

    logic [EXT_W-1:0]  h_ext;
    logic [EXT_W-1:0]  v_ext;
    logic [EXT_W-1:0]  rel_x;
    logic [EXT_W-1:0]  rel_y;
    logic              in_card;

    logic              in_card_d;
    logic [RGB_W-1:0]  rgb_d;
    logic              show_rom;

    vga_timing_t       timing_in;
    vga_timing_t       timing_out;

    // NOTE: registers use non-blocking assignments so every flop samples its inputs
    // from the same pre-edge state regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            xpos_l     <= '0;
            ypos_l     <= '0;
            card_en_l  <= 1'b0;
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_in && !vblnk_prev) begin
                xpos_l    <= xpos;
                ypos_l    <= ypos;
                card_en_l <= card_en;
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        h_ext   = EXT_W'(hcount_in);
        v_ext   = EXT_W'(vcount_in);
        rel_x   = h_ext - EXT_W'(xpos_l);
        rel_y   = v_ext - EXT_W'(ypos_l);
        in_card = 1'b0;
        if (card_en_l && !hblnk_in && !vblnk_in
            && (h_ext >= EXT_W'(xpos_l)) && (rel_x < EXT_W'(CARD_WIDTH))
            && (v_ext >= EXT_W'(ypos_l)) && (rel_y < EXT_W'(CARD_HEIGHT))) begin
            in_card = 1'b1;
        end
    end

    // Stage 1: address the ROM and carry the flag and background alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr  <= '0;
            in_card_d <= 1'b0;
            rgb_d     <= '0;
        end else begin
            rom_addr  <= in_card ? card_rom_addr(rel_y[CARD_ROW_W-1:0], rel_x[CARD_COL_W-1:0])
                                 : '0;
            in_card_d <= in_card;
            rgb_d     <= rgb_in;
        end
    end

`ifdef DRAW_CARD_TRANSPARENT_EN
    assign show_rom = in_card_d && (rom_rgb != TRANSPARENT_RGB);
`else
    assign show_rom = in_card_d;
`endif

    // Stage 2: ROM data is valid now; choose between card and background.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= show_rom ? rom_rgb : rgb_d;
        end
    end

    assign timing_in = '{
        hcount: hcount_in,
        vcount: vcount_in,
        hsync:  hsync_in,
        vsync:  vsync_in,
        hblnk:  hblnk_in,
        vblnk:  vblnk_in
    };

    delay #(
        .WIDTH   (TIMING_W),
        .CLK_DEL (DLY)
    ) u_timing_dly (
        .clk (clk),
        .rst (rst),
        .d   (timing_in),
        .q   (timing_out)
    );

    assign hcount_out = timing_out.hcount;
    assign vcount_out = timing_out.vcount;
    assign hsync_out  = timing_out.hsync;
    assign vsync_out  = timing_out.vsync;
    assign hblnk_out  = timing_out.hblnk;
    assign vblnk_out  = timing_out.vblnk;

endmodule

// File: tb/tb_draw_card.sv
// Directed bench for draw_card: a per-cycle reference model pushes expected outputs to a
// scoreboard; results are popped and compared two clocks later, one cycle at a time.
module tb_draw_card;
    import vga_pkg::*;

    typedef struct packed {
        logic [25:0] tim;
        logic [11:0] rgb;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        card_en;
    logic [11:0] rom_addr;
    logic [11:0] rom_rgb;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    logic        rom_force;
    logic [11:0] m_x;
    logic [11:0] m_y;
    logic        m_en;
    logic        m_pv;
    exp_t        sb[$];
    int          n_checks;
    int          n_pass;

    draw_card dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .card_en    (card_en),
        .rom_addr   (rom_addr),
        .rom_rgb    (rom_rgb),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    // ROM model: data equals address, except address 0 may be forced to the key colour.
    assign rom_rgb = (rom_force && rom_addr == 12'd0) ? TRANSPARENT_RGB : rom_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one pixel, model it, clock it, then compare rom_addr and the 2-cycle-old output.
    task automatic step(input logic r, input logic [10:0] h, input logic [10:0] v,
                        input logic hb, input logic vb, input logic [11:0] rgb);
        int          rx;
        int          ry;
        logic        inc;
        logic        show;
        logic [11:0] ea;
        logic [11:0] romv;
        logic        hs;
        logic        vs;
        exp_t        e;
        exp_t        old;

        hs = 1'($urandom);
        vs = 1'($urandom);
        rst = r; hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
        hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;

        rx  = int'(h) - int'(m_x);
        ry  = int'(v) - int'(m_y);
        inc = !r && m_en && !hb && !vb && rx >= 0 && rx < CARD_WIDTH && ry >= 0 && ry < CARD_HEIGHT;
        ea  = inc ? 12'(ry * 64 + rx) : 12'd0;
        romv = (rom_force && ea == 12'd0) ? TRANSPARENT_RGB : ea;
`ifdef DRAW_CARD_TRANSPARENT_EN
        show = inc && (romv != TRANSPARENT_RGB);
`else
        show = inc;
`endif
        e.tim = r ? 26'd0 : {h, v, hs, vs, hb, vb};
        e.rgb = r ? 12'd0 : (show ? romv : rgb);

        if (r) begin
            m_x = '0; m_y = '0; m_en = 1'b0; m_pv = 1'b0;
        end else begin
            if (vb && !m_pv) begin
                m_x = xpos; m_y = ypos; m_en = card_en;
            end
            m_pv = vb;
        end

        @(posedge clk);
        #1;
        check("rom_addr", 64'(rom_addr), 64'(ea));
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 64'(1), 64'(0));
            old = '0;
        end else begin
            old = sb.pop_front();
        end
        if (r) old = '0;
        check("timing_out", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
              64'(old.tim));
        check("rgb_out", 64'(rgb_out), 64'(old.rgb));
        sb.push_back(e);
    endtask

    task automatic row(input int v, input int h0, input int h1, input logic hb);
        for (int h = h0; h <= h1; h++) begin
            step(1'b0, 11'(h), 11'(v), hb, 1'b0, 12'($urandom));
        end
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 11'(i), 11'd600, 1'b1, 1'b1, 12'($urandom));
        end
    endtask

    initial begin
        logic [11:0] bg;
        n_checks = 0; n_pass = 0;
        rom_force = 1'b0;
        xpos = '0; ypos = '0; card_en = 1'b0;
        m_x = '0; m_y = '0; m_en = 1'b0; m_pv = 1'b0;
        sb.push_back('0);

        // Reset with random inputs, then background passes through until the first vblank.
        xpos = 12'd10; ypos = 12'd10; card_en = 1'b1;
        repeat (3) step(1'b1, 11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
        check("reset_rom_addr", 64'(rom_addr), 64'(0));
        check("reset_rgb_out", 64'(rgb_out), 64'(0));
        repeat (8) step(1'b0, 11'($urandom_range(799)), 11'($urandom_range(599)), 1'b0, 1'b0, 12'($urandom));

        // Placement at (100,50).
        xpos = 12'd100; ypos = 12'd50; card_en = 1'b1;
        vblank(3);
        row(49, 98, 102, 1'b0);
        row(50, 98, 104, 1'b0);
        step(1'b0, 11'd101, 11'd50, 1'b0, 1'b0, 12'h123);
        check("addr_first_row", 64'(rom_addr), 64'(12'h001));
        row(113, 140, 146, 1'b0);
        step(1'b0, 11'd147, 11'd113, 1'b0, 1'b0, 12'h456);
        check("addr_last_corner", 64'(rom_addr), 64'(12'hFEF));
        row(113, 148, 150, 1'b0);
        row(114, 100, 103, 1'b0);

        // Frame latch: mid-frame xpos change waits for the next vblank.
        row(60, 98, 102, 1'b0);
        xpos = 12'd300;
        row(200, 0, 3, 1'b0);
        row(70, 98, 102, 1'b0);
        row(70, 298, 302, 1'b0);
        vblank(3);
        row(70, 98, 102, 1'b0);
        row(70, 298, 302, 1'b0);
        row(70, 345, 350, 1'b0);

        // Clipping at the right edge, blanking overlap, and no wrap onto the next line.
        xpos = 12'd780; ypos = 12'd50;
        vblank(2);
        row(55, 776, 799, 1'b0);
        row(55, 800, 830, 1'b1);
        row(56, 0, 30, 1'b0);

        // Card disabled for a whole frame.
        xpos = 12'd100; card_en = 1'b0;
        vblank(2);
        row(50, 95, 150, 1'b0);
        row(113, 140, 150, 1'b0);

        // Key colour at ROM address 0.
        card_en = 1'b1; rom_force = 1'b1;
        vblank(2);
        row(50, 98, 99, 1'b0);
        bg = 12'h0A5;
        step(1'b0, 11'd100, 11'd50, 1'b0, 1'b0, bg);
        step(1'b0, 11'd101, 11'd50, 1'b0, 1'b0, 12'h777);
`ifdef DRAW_CARD_TRANSPARENT_EN
        check("transparent_px", 64'(rgb_out), 64'(12'h0A5));
`else
        check("transparent_px", 64'(rgb_out), 64'(12'hF0F));
`endif
        row(50, 102, 104, 1'b0);

        // Mid-frame reset clears the pipeline and the latched card.
        rom_force = 1'b0;
        row(51, 100, 104, 1'b0);
        repeat (2) step(1'b1, 11'd105, 11'd51, 1'b0, 1'b0, 12'($urandom));
        row(51, 106, 112, 1'b0);
        vblank(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
